// File: rtl/t_clk_driver.sv
// t_clk_driver: clock/reset stimulus and pass/fail watcher for the clock test.
// Divides fastclk into clk_o, holds the DUT in reset for RST_CYCLES clk_o
// rises, then watches the DUT's passed flag until PASS or a timeout FAIL.
module t_clk_driver #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       fastclk,
  input  logic       reset_l,
  input  logic       passed,
  output logic       clk_o,
  output logic       reset_o_l,
  output logic [7:0] cyc,
  output logic [1:0] state,
  output logic       done,
  output logic       fail
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT);

  state_t     st;
  logic [7:0] div_cnt;
  logic [7:0] rst_cnt;
  logic       tick;
  logic       rise;
  logic       fall;

  // Decode this cycle's divider event: a toggle is a rise or a fall of clk_o
  always_comb begin
    tick = (div_cnt == DIV_LAST);
    rise = tick && !clk_o;
    fall = tick && clk_o;
  end

  // Sequencer: divider, reset hold, run monitor and terminal states
  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      st        <= ST_RESET;
      div_cnt   <= 8'd0;
      rst_cnt   <= 8'd0;
      clk_o     <= 1'b0;
      reset_o_l <= 1'b0;
      cyc       <= 8'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (st)
        ST_RESET: begin
          if (tick) begin
            div_cnt <= 8'd0;
            clk_o   <= ~clk_o;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
          if (rise) begin
            rst_cnt <= rst_cnt + 8'd1;
          end
          // A pass flag seen while the DUT is still held in reset is bogus
          if (fall) begin
            if (passed) begin
              st   <= ST_FAIL;
              done <= 1'b1;
              fail <= 1'b1;
            end else if (rst_cnt >= RST_LAST) begin
              st        <= ST_RUN;
              reset_o_l <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (tick) begin
            div_cnt <= 8'd0;
            clk_o   <= ~clk_o;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
          if (rise) begin
            cyc <= cyc + 8'd1;
          end
          // passed is only trusted on fall cycles; it beats the timeout
          if (fall) begin
            if (passed) begin
              st   <= ST_PASS;
              done <= 1'b1;
            end else if (cyc == TMO_LAST) begin
              st   <= ST_FAIL;
              done <= 1'b1;
              fail <= 1'b1;
            end
          end
        end
        default: begin
          // PASS/FAIL are terminal: the entering fall left clk_o low, so
          // everything simply holds until reset_l
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_t_clk_driver.sv
// Self-checking bench for t_clk_driver: directed vector table, hand-written
// corner sequences and randomized passed stimulus against a timing model.
module tb_t_clk_driver;

  localparam int DIV  = 4;
  localparam int RSTC = 3;
  localparam int TMO  = 64;
  localparam int REL  = 2 * DIV * RSTC;

  logic       fastclk = 1'b0;
  logic       reset_l = 1'b0;
  logic       passed  = 1'b0;
  logic       clk_o, reset_o_l, done, fail;
  logic [7:0] cyc;
  logic [1:0] state;

  logic       reset_l1 = 1'b0;
  logic       passed1  = 1'b0;
  logic       clk_o1, reset_o_l1, done1, fail1;
  logic [7:0] cyc1;
  logic [1:0] state1;

  t_clk_driver #(.DIV(DIV), .RST_CYCLES(RSTC), .TIMEOUT(TMO)) dut (
    .fastclk(fastclk), .reset_l(reset_l), .passed(passed),
    .clk_o(clk_o), .reset_o_l(reset_o_l), .cyc(cyc),
    .state(state), .done(done), .fail(fail)
  );

  t_clk_driver #(.DIV(1), .RST_CYCLES(1), .TIMEOUT(2)) dut1 (
    .fastclk(fastclk), .reset_l(reset_l1), .passed(passed1),
    .clk_o(clk_o1), .reset_o_l(reset_o_l1), .cyc(cyc1),
    .state(state1), .done(done1), .fail(fail1)
  );

  always #5 fastclk = ~fastclk;

  int n_pass  = 0;
  int n_total = 0;
  int n       = 0;   // fastclk rising edges since reset_l release

  // reference model, expressed through the edge-number timing rules
  int m_clk, m_rst, m_cyc, m_state;

  typedef struct {
    int at_edge;
    int clk;
    int rst;
    int cy;
    int st;
    int dn;
    int fl;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0d expected=%0d", name, n, act, exp);
  endtask

  task automatic model_init();
    m_clk = 0; m_rst = 0; m_cyc = 0; m_state = 0;
  endtask

  // Advance the model to edge n with the passed value seen at that edge
  task automatic model_edge(input int p);
    if (m_state < 2) begin
      m_clk = ((n / DIV) % 2 == 1) ? 1 : 0;
      if (m_state == 1) m_cyc = (n - REL + DIV) / (2 * DIV);
      if (n % (2 * DIV) == 0) begin
        if (m_state == 0) begin
          if (p != 0) m_state = 3;
          else if (n >= REL) begin m_state = 1; m_rst = 1; end
        end else begin
          if (p != 0) m_state = 2;
          else if (m_cyc == TMO) m_state = 3;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_clk_o"}, int'(clk_o), m_clk);
    check({tag, "_reset_o_l"}, int'(reset_o_l), m_rst);
    check({tag, "_cyc"}, int'(cyc), m_cyc);
    check({tag, "_state"}, int'(state), m_state);
    check({tag, "_done"}, int'(done), (m_state >= 2) ? 1 : 0);
    check({tag, "_fail"}, int'(fail), (m_state == 3) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge fastclk);
    n++;
    model_edge(int'(passed));
    #1;
    check_all("model");
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    passed  = 1'b0;
    repeat (3) @(posedge fastclk);
    #1;
    n = 0;
    model_init();
    check_all("rst");
    @(negedge fastclk);
    reset_l = 1'b1;
  endtask

  initial begin
    int e_clk[8];
    int e_rst[8];
    int e_cyc[8];
    int e_st[8];
    int p_at;

    // ---- DIV=1, RST_CYCLES=1, TIMEOUT=2 corner (second instance) ----
    e_clk = '{1, 0, 1, 0, 1, 0, 0, 0};
    e_rst = '{0, 1, 1, 1, 1, 1, 1, 1};
    e_cyc = '{0, 0, 1, 1, 2, 2, 2, 2};
    e_st  = '{0, 1, 1, 1, 1, 3, 3, 3};
    repeat (3) @(posedge fastclk);
    #1;
    check("d1_rst_clk_o", int'(clk_o1), 0);
    check("d1_rst_state", int'(state1), 0);
    @(negedge fastclk);
    reset_l1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge fastclk);
      #1;
      n = i + 1;
      check("d1_clk_o", int'(clk_o1), e_clk[i]);
      check("d1_reset_o_l", int'(reset_o_l1), e_rst[i]);
      check("d1_cyc", int'(cyc1), e_cyc[i]);
      check("d1_state", int'(state1), e_st[i]);
      check("d1_fail", int'(fail1), (e_st[i] == 3) ? 1 : 0);
    end

    // ---- directed vector table, defaults, passed held 0 ----
    tbl[0]  = '{3,   0, 0, 0,  0, 0, 0};
    tbl[1]  = '{4,   1, 0, 0,  0, 0, 0};
    tbl[2]  = '{8,   0, 0, 0,  0, 0, 0};
    tbl[3]  = '{12,  1, 0, 0,  0, 0, 0};
    tbl[4]  = '{23,  1, 0, 0,  0, 0, 0};
    tbl[5]  = '{24,  0, 1, 0,  1, 0, 0};
    tbl[6]  = '{28,  1, 1, 1,  1, 0, 0};
    tbl[7]  = '{531, 0, 1, 63, 1, 0, 0};
    tbl[8]  = '{532, 1, 1, 64, 1, 0, 0};
    tbl[9]  = '{535, 1, 1, 64, 1, 0, 0};
    tbl[10] = '{536, 0, 1, 64, 3, 1, 1};
    tbl[11] = '{600, 0, 1, 64, 3, 1, 1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_to(tbl[i].at_edge);
      check("tbl_clk_o", int'(clk_o), tbl[i].clk);
      check("tbl_reset_o_l", int'(reset_o_l), tbl[i].rst);
      check("tbl_cyc", int'(cyc), tbl[i].cy);
      check("tbl_state", int'(state), tbl[i].st);
      check("tbl_done", int'(done), tbl[i].dn);
      check("tbl_fail", int'(fail), tbl[i].fl);
    end

    // ---- passed after the 5th RUN rise -> PASS at edge 64, then frozen ----
    do_reset();
    run_to(60);
    passed = 1'b1;
    run_to(64);
    check("pass5_state", int'(state), 2);
    check("pass5_done", int'(done), 1);
    check("pass5_fail", int'(fail), 0);
    check("pass5_cyc", int'(cyc), 5);
    run_to(164);
    check("pass5_frozen_cyc", int'(cyc), 5);
    check("pass5_frozen_clk", int'(clk_o), 0);

    // ---- passed high during RESET -> FAIL at edge 8, DUT kept in reset ----
    do_reset();
    passed = 1'b1;
    run_to(8);
    check("early_state", int'(state), 3);
    check("early_fail", int'(fail), 1);
    run_to(40);
    check("early_reset_o_l", int'(reset_o_l), 0);

    // ---- passed arrives with the cyc==TIMEOUT rise -> PASS wins ----
    do_reset();
    run_to(531);
    passed = 1'b1;
    run_to(536);
    check("race_state", int'(state), 2);
    check("race_fail", int'(fail), 0);
    check("race_cyc", int'(cyc), 64);

    // ---- asynchronous reset mid-RUN while clk_o is high ----
    do_reset();
    run_to(300);
    reset_l = 1'b0;
    #1;
    check("async_clk_o", int'(clk_o), 0);
    check("async_reset_o_l", int'(reset_o_l), 0);
    check("async_cyc", int'(cyc), 0);
    check("async_state", int'(state), 0);
    do_reset();
    run_to(23);
    check("restart_rst_low", int'(reset_o_l), 0);
    run_to(24);
    check("restart_rst_high", int'(reset_o_l), 1);

    // ---- randomized passed stimulus against the model ----
    for (int r = 0; r < 6; r++) begin
      do_reset();
      p_at = $urandom_range(1, 560);
      for (int c = 0; c < 620; c++) begin
        step();
        if (r % 2 == 0) passed = (n >= p_at) ? 1'b1 : 1'b0;
        else passed = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
